// File: rtl/frame_ram_sched.sv
// frame_ram_sched
//   Owns the single-port image RAM port and the system state byte. It runs
//   the frame load (an upstream loader streams W*H pixels into the RAM) and,
//   once a frame is loaded and display is enabled, generates raster-ordered
//   read addresses while the VGA scan is inside the display window.
//   Loader writes and display reads are never issued in the same state, so
//   the two RAM users cannot collide.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   W, H                      window size in pixels
//   STARTROW, STARTCOL        window origin on the scan grid
//   xpos, ypos                current scan position
//   load_start                one-cycle pulse: begin a frame load
//   show_en                   level: allow display once a frame is loaded
//   wr_req, wr_data, wr_ack   loader pixel handshake (ack is combinational)
//   load_done                 one-cycle pulse with the final RAM write
//   state                     system state code
//   ram_addr/we/wdata/rdata   synchronous RAM port, 1-cycle read latency
//   pixel_data, pixel_valid   display output, 2 cycles after the scan sample
module frame_ram_sched #(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        W,
  input  logic [7:0]        H,
  input  logic [9:0]        STARTROW,
  input  logic [9:0]        STARTCOL,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              load_start,
  input  logic              show_en,
  input  logic              wr_req,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              load_done,
  output logic [7:0]        state,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              pixel_valid
);

  typedef enum logic [7:0] {
    S_IDLE    = 8'h00,
    S_LOAD    = 8'h01,
    S_READY   = 8'h02,
    S_DISPLAY = 8'h03
  } state_t;

  state_t cur_state, nxt_state;

  // Load bookkeeping: a linear address plus column/row counters, so the end
  // of the frame is detected without forming W*H.
  logic [ADDR_W-1:0] wr_cnt;
  logic [7:0]        wr_col, wr_row;
  logic              dims_zero, last_pix, accept;

  // Window geometry in 13 bits so STARTCOL+W / STARTROW+H cannot wrap.
  logic [12:0] x13, y13, col_lo, col_hi, row_lo, row_hi, x_off;
  logic        in_win, row_end, above_win, disp_hit;
  logic [ADDR_W-1:0] row_base;
  logic        hit_d1, hit_d2;

  assign dims_zero = (W == 8'd0) || (H == 8'd0);
  assign last_pix  = (wr_col >= W - 8'd1) && (wr_row >= H - 8'd1);
  assign accept    = (cur_state == S_LOAD) && wr_req && !dims_zero;

  assign x13       = {1'b0, xpos};
  assign y13       = {1'b0, ypos};
  assign col_lo    = {3'b000, STARTCOL};
  assign row_lo    = {3'b000, STARTROW};
  assign col_hi    = col_lo + {5'b00000, W};
  assign row_hi    = row_lo + {5'b00000, H};
  assign x_off     = x13 - col_lo;
  assign in_win    = (x13 >= col_lo) && (x13 < col_hi) &&
                     (y13 >= row_lo) && (y13 < row_hi);
  assign row_end   = in_win && (x13 == col_hi - 13'd1);
  assign above_win = y13 < row_lo;
  assign disp_hit  = (cur_state == S_DISPLAY) && in_win;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_IDLE;
    else     cur_state <= nxt_state;
  end

  // Next-state logic. load_start is ignored while a load is in progress.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:    if (load_start) nxt_state = S_LOAD;
      S_LOAD:    if (dims_zero || (accept && last_pix)) nxt_state = S_READY;
      S_READY:   if (load_start) nxt_state = S_LOAD;
                 else if (show_en) nxt_state = S_DISPLAY;
      S_DISPLAY: if (load_start) nxt_state = S_LOAD;
                 else if (!show_en) nxt_state = S_READY;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    state  = cur_state;
    wr_ack = accept;
  end

  // RAM port and load counters. The address register is shared: loader
  // writes own it in LOAD, display reads own it in DISPLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      wr_col    <= '0;
      wr_row    <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      load_done <= 1'b0;
    end else begin
      ram_we    <= accept;
      load_done <= (cur_state == S_LOAD) && (dims_zero || (accept && last_pix));
      if (cur_state != S_LOAD && nxt_state == S_LOAD) begin
        wr_cnt <= '0;
        wr_col <= '0;
        wr_row <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
        if (wr_col >= W - 8'd1) begin
          wr_col <= '0;
          wr_row <= wr_row + 8'd1;
        end else begin
          wr_col <= wr_col + 8'd1;
        end
      end
      if (accept) begin
        ram_addr  <= wr_cnt;
        ram_wdata <= wr_data;
      end else if (disp_hit) begin
        ram_addr <= row_base + ADDR_W'(x_off);
      end
    end
  end

  // Start address of the current window row; advances by W after the last
  // pixel of each row, so no multiplier is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
    end else if (cur_state != S_DISPLAY || above_win) begin
      row_base <= '0;
    end else if (row_end) begin
      row_base <= row_base + ADDR_W'(W);
    end
  end

  // Qualifier pipeline aligned with the address register and the RAM's
  // read latency; out-of-window slots deliver zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_d1      <= 1'b0;
      hit_d2      <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
    end else begin
      hit_d1      <= disp_hit;
      hit_d2      <= hit_d1;
      pixel_valid <= hit_d2;
      pixel_data  <= hit_d2 ? ram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_frame_ram_sched.sv
// tb_frame_ram_sched
//   Randomized self-checking bench for frame_ram_sched. A behavioural RAM
//   sits on the RAM port; a reference model tracks the system state, the
//   loaded frame contents and the expected pixel stream, computing pixel
//   addresses directly as (y-STARTROW)*W + (x-STARTCOL).
module tb_frame_ram_sched;

  localparam int ADDR_W = 15;
  localparam int PIX_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        W, H;
  logic [9:0]        STARTROW, STARTCOL;
  logic [11:0]       xpos, ypos;
  logic              load_start, show_en, wr_req;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ack, load_done, ram_we, pixel_valid;
  logic [7:0]        state;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_wdata, ram_rdata, pixel_data;

  frame_ram_sched #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .W(W), .H(H), .STARTROW(STARTROW),
    .STARTCOL(STARTCOL), .xpos(xpos), .ypos(ypos), .load_start(load_start),
    .show_en(show_en), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .load_done(load_done), .state(state), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write, 1-cycle latency.
  logic [PIX_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int tests_run = 0;
  int tests_failed = 0;
  int ref_frame [65536];
  int m_state;
  bit hv [3];
  int hd [3];

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearHistory;
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      hd[i] = 0;
    end
  endtask

  task automatic startLoad;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_state = 1;
    checkOutput("state_enter_load", state, 32'h1);
  endtask

  // Streams n pixels. mode 0: wr_req always high, 1: alternating, 2: random.
  // dmode 0: random data, 1: data = index, 2: data = 0x100 + index.
  task automatic fillFrame(input int n, input int mode, input int dmode);
    int idx = 0;
    int cyc = 0;
    int budget = n * 10 + 20;
    if (n == 0) begin
      tick();
      checkOutput("zero_load_done", load_done, 32'h1);
      checkOutput("zero_no_we", ram_we, 32'h0);
      checkOutput("zero_state", state, 32'h2);
      tick();
      checkOutput("zero_done_once", load_done, 32'h0);
      m_state = 2;
      return;
    end
    while (idx < n && budget > 0) begin
      budget--;
      case (mode)
        0:       wr_req = 1'b1;
        1:       wr_req = (cyc % 2) == 0;
        default: wr_req = $urandom_range(0, 2) != 0;
      endcase
      case (dmode)
        1:       wr_data = PIX_W'(idx);
        2:       wr_data = PIX_W'(32'h100 + idx);
        default: wr_data = PIX_W'($urandom_range(0, 4095));
      endcase
      load_start = ($urandom_range(0, 7) == 0);
      #1;
      checkOutput("wr_ack", wr_ack, wr_req);
      tick();
      if (wr_req) begin
        ref_frame[idx] = wr_data;
        checkOutput("ram_we", ram_we, 32'h1);
        checkOutput("ram_addr_wr", ram_addr, idx);
        checkOutput("ram_wdata", ram_wdata, wr_data);
        checkOutput("load_done", load_done, (idx == n - 1) ? 1 : 0);
        idx++;
      end else begin
        checkOutput("ram_we_idle", ram_we, 32'h0);
        checkOutput("load_done_idle", load_done, 32'h0);
      end
      checkOutput("state_load", state, (idx == n) ? 2 : 1);
      cyc++;
    end
    wr_req = 1'b0;
    load_start = 1'b0;
    if (idx < n) checkOutput("load_timeout", idx, n);
    tick();
    checkOutput("load_done_once", load_done, 32'h0);
    checkOutput("state_ready", state, 32'h2);
    m_state = 2;
  endtask

  // One scan cycle: drive position and controls, advance, compare the
  // pixel output against the sample taken two edges earlier.
  task automatic applyStimulus(input int x, input int y, input bit ls, input bit se);
    int sc, sr, w, h;
    bit cur_v;
    int cur_d;
    sc = int'(STARTCOL); sr = int'(STARTROW); w = int'(W); h = int'(H);
    xpos = 12'(x); ypos = 12'(y); load_start = ls; show_en = se;
    cur_v = (m_state == 3) && x >= sc && x < sc + w && y >= sr && y < sr + h;
    cur_d = cur_v ? ref_frame[(y - sr) * w + (x - sc)] : 0;
    case (m_state)
      0: if (ls) m_state = 1;
      2: if (ls) m_state = 1; else if (se) m_state = 3;
      3: if (ls) m_state = 1; else if (!se) m_state = 2;
      default: ;
    endcase
    tick();
    hv[2] = hv[1]; hd[2] = hd[1];
    hv[1] = hv[0]; hd[1] = hd[0];
    hv[0] = cur_v; hd[0] = cur_d;
    checkOutput("pixel_valid", pixel_valid, hv[2]);
    checkOutput("pixel_data", pixel_data, hd[2]);
    checkOutput("state_scan", state, m_state);
    load_start = 1'b0;
  endtask

  task automatic displayScan(input int y0, input int y1, input int x0, input int x1);
    clearHistory();
    applyStimulus(0, 0, 1'b0, 1'b1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        applyStimulus(x, y, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    W = 8'd4; H = 8'd3; STARTROW = 10'd5; STARTCOL = 10'd10;
    xpos = '0; ypos = '0; load_start = 1'b0; show_en = 1'b0;
    wr_req = 1'b0; wr_data = '0;
    m_state = 0;
    clearHistory();
    #12;
    checkOutput("rst_state", state, 32'h0);
    checkOutput("rst_ram_we", ram_we, 32'h0);
    checkOutput("rst_ram_addr", ram_addr, 32'h0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'h0);
    checkOutput("rst_load_done", load_done, 32'h0);
    checkOutput("rst_pixel_valid", pixel_valid, 32'h0);
    checkOutput("rst_pixel_data", pixel_data, 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a 4x3 load.
    startLoad();
    for (int i = 0; i < 10; i++) begin
      wr_req = 1'b1;
      wr_data = PIX_W'($urandom_range(0, 4095));
      tick();
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_state", state, 32'h0);
    checkOutput("midrst_ram_we", ram_we, 32'h0);
    checkOutput("midrst_wr_ack", wr_ack, 32'h0);
    wr_req = 1'b0;
    tick();
    rst = 1'b0;
    m_state = 0;
    tick();

    // Full load restarting at address 0, data 0x100..0x10B.
    W = 8'd4; H = 8'd3;
    startLoad();
    fillFrame(12, 0, 2);

    // Gapped writes: alternating, then random.
    startLoad();
    fillFrame(12, 1, 0);
    startLoad();
    fillFrame(12, 2, 0);

    // Display scan of an addr=value frame.
    STARTCOL = 10'd10; STARTROW = 10'd5;
    startLoad();
    fillFrame(12, 0, 1);
    displayScan(4, 8, 8, 15);

    // Reload in the middle of the display.
    clearHistory();
    applyStimulus(0, 0, 1'b0, 1'b1);
    for (int x = 8; x <= 15; x++) applyStimulus(x, 4, 1'b0, 1'b1);
    for (int x = 8; x <= 11; x++) applyStimulus(x, 5, 1'b0, 1'b1);
    applyStimulus(12, 5, 1'b1, 1'b1);
    applyStimulus(13, 5, 1'b0, 1'b1);
    applyStimulus(14, 5, 1'b0, 1'b1);
    applyStimulus(15, 5, 1'b0, 1'b1);
    wr_req = 1'b1;
    #1;
    checkOutput("reload_wr_ack", wr_ack, 32'h1);
    wr_req = 1'b0;
    show_en = 1'b0;
    fillFrame(12, 2, 0);

    // Zero-sized windows.
    W = 8'd0; H = 8'd3; STARTCOL = 10'd2; STARTROW = 10'd1;
    startLoad();
    fillFrame(0, 0, 0);
    displayScan(0, 4, 0, 12);
    W = 8'd5; H = 8'd0;
    startLoad();
    fillFrame(0, 0, 0);
    displayScan(0, 2, 0, 8);

    // Wide window near the right edge of the column range.
    W = 8'd255; H = 8'd1; STARTCOL = 10'd1000; STARTROW = 10'd3;
    startLoad();
    fillFrame(255, 2, 0);
    displayScan(2, 4, 998, 1256);

    // Random windows.
    for (int it = 0; it < 4; it++) begin
      int w, h, sc, sr;
      w  = $urandom_range(1, 12);
      h  = $urandom_range(1, 5);
      sc = $urandom_range(0, 1000);
      sr = $urandom_range(1, 600);
      W = 8'(w); H = 8'(h); STARTCOL = 10'(sc); STARTROW = 10'(sr);
      startLoad();
      fillFrame(w * h, 2, 0);
      displayScan(sr - 1, sr + h, (sc >= 2) ? sc - 2 : 0, sc + w + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_ram_sched.md
Name: frame_ram_sched

Overview:
- Owns the single-port image RAM and the system state byte.
- Sequences the frame load: an upstream writer (UART/SD loader) fills W*H pixels.
- Once the frame is loaded and enabled, generates raster-ordered read addresses while the VGA scan is inside the display window.
- Delivers a pipelined pixel_data/pixel_valid pair to the display stage, and arbitrates RAM access so loader writes and display reads never collide.

Parameters:
- ADDR_W, 15: RAM address width; 200*150 = 30000 < 2^15.
- PIX_W, 12: pixel width in RGB444.

Ports:
- clk, in, 1: system/pixel clock.
- rst, in, 1: asynchronous, active-high reset.
- W, in, 8: window width in pixels.
- H, in, 8: window height in pixels.
- STARTROW, in, 10: first window row.
- STARTCOL, in, 10: first window column.
- xpos, in, 12: current scan column.
- ypos, in, 12: current scan row.
- load_start, in, 1: one-cycle pulse; begin a frame load.
- show_en, in, 1: level; allow display once the frame is loaded.
- wr_req, in, 1: loader has a pixel on wr_data.
- wr_data, in, PIX_W: loader pixel.
- wr_ack, out, 1: pixel accepted this cycle.
- load_done, out, 1: one-cycle pulse when the last pixel is written.
- state, out, 8: system state code.
- ram_addr, out, ADDR_W: RAM address (registered).
- ram_we, out, 1: RAM write enable (registered).
- ram_wdata, out, PIX_W: RAM write data (registered).
- ram_rdata, in, PIX_W: RAM read data, synchronous RAM, 1-cycle latency.
- pixel_data, out, PIX_W: pixel for the display stage.
- pixel_valid, out, 1: pixel_data belongs to the window.

Behaviour:

Reset:
- rst asserted (async): state=8'h00, ram_addr=0, ram_we=0, ram_wdata=0, wr_ack=0, load_done=0, pixel_data=0, pixel_valid=0.
- Write counter and row_base cleared.
- Reset mid-load abandons the load; no resume.

State machine (state output = code):
- IDLE, 8'h00:
  - load_start -> LOAD; write counter cleared.
- LOAD, 8'h01:
  - wr_ack = wr_req, combinational, same cycle.
  - On each accepted pixel: ram_addr<=count, ram_wdata<=wr_data, ram_we<=1 on the next edge; count++.
  - When the accepted pixel has count == W*H-1: load_done pulses on the same edge as the final ram_we, then -> READY.
  - W*H == 0: -> READY on the cycle after entry with a load_done pulse and no writes.
  - load_start while in LOAD is ignored.
- READY, 8'h02:
  - show_en=1 -> DISPLAY.
  - load_start -> LOAD (takes priority over show_en).
- DISPLAY, 8'h03:
  - load_start -> LOAD.
  - Otherwise, show_en=0 -> READY.
  - wr_ack held 0; ram_we held 0.
- Outside LOAD: ram_we=0 and wr_ack=0 in all other states.

Window and addressing (DISPLAY only):
- in_win = xpos in [STARTCOL, STARTCOL+W) and ypos in [STARTROW, STARTROW+H).
- Compare in 13-bit unsigned arithmetic so STARTCOL+W does not wrap.
- row_base (ADDR_W bits):
  - Cleared when ypos < STARTROW, and on entry to DISPLAY.
  - Incremented by W on the cycle where in_win and xpos == STARTCOL+W-1.
  - Not reset by that same increment.
- Address: each in_win cycle registers ram_addr <= row_base + (xpos-STARTCOL).
- No multiplier is permitted.
- Latency from sampling (xpos, ypos) at edge t:
  - ram_addr valid after t.
  - ram_rdata valid after t+1.
  - pixel_data <= ram_rdata and pixel_valid <= 1 at edge t+2.
- Total 2-cycle latency; the downstream display stage delays its window qualifier to match.
- Outside the window: ram_addr holds its last value; pixel_valid goes 0 and pixel_data goes 0 with the same 2-cycle alignment.
- Leaving DISPLAY: pixel_valid and pixel_data drop to 0 two cycles later. The in-flight pipeline drains with valid=0.

Simultaneous events:
- rst wins over everything.
- A final pixel accepted on the same cycle as load_start: completes to READY; load_start is ignored.
- A W/H/STARTROW/STARTCOL change during DISPLAY takes effect immediately. The frame may tear; this is accepted behaviour, not an error.

Test Plan:
1. Reset mid-load: assert rst after 10 pixels of a 4x3 load -> state=8'h00, ram_we=0, count restarts at 0 on the next load_start.
2. Full load, W=4, H=3:
   - Stimulus: load_start, then wr_req held high for 12 cycles with data 12'h100..12'h10B.
   - Required: ram_we pulses at addresses 0..11 with matching data.
   - Required: load_done pulses exactly once with address 11; state 8'h01 -> 8'h02.
3. Gapped writes: wr_req toggles 1,0,1,0 -> wr_ack mirrors wr_req; only acked pixels are written; addresses stay contiguous.
4. Display scan, W=4, H=3, STARTCOL=10, STARTROW=5, show_en=1, RAM preloaded addr=value:
   - Scan x=8..15 over rows 4..8.
   - Required pixel_data sequence: 0..3, 4..7, 8..11.
   - pixel_valid high exactly for 12 cycles, each 2 cycles after the in-window xpos; 0 elsewhere.
5. Reload during display: load_start in DISPLAY -> state=8'h01 next cycle; pixel_valid drops within 2 cycles; wr_ack becomes live.
6. Edge windows:
   - W=0 or H=0 -> load_done the cycle after entering LOAD, no ram_we; in DISPLAY, pixel_valid never asserts.
   - STARTCOL=1000, W=255 -> no wrap; window covers x 1000..1254.
